fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage of the 8-bit MIPS core. Directly upstream of instructionMemory:
//   owns the program counter and drives the memory address. Captures the returned
//   instruction into the IF/ID pipeline register that feeds decode.
//   Supports stall, branch/jump redirect with flush, and a halt state entered on HALT_INSTR.
// PARAMETERS
//   ADDR_WIDTH   8       PC / instruction-memory address width
//   INSTR_WIDTH  8       instruction width
//   RESET_PC     8'h00   PC value loaded on reset
//   HALT_INSTR   8'hFF   encoding that stops fetching
//   NOP_INSTR    8'h00   value placed in IF/ID on reset or flush
// PORTS
//   clock            in   1            rising-edge clock
//   reset            in   1            synchronous, active-high
//   stall            in   1            decode/hazard unit: hold PC and IF/ID
//   redirect         in   1            branch/jump taken: load redirect_target, flush IF/ID
//   redirect_target  in   ADDR_WIDTH   new PC when redirect=1
//   instruction_in   in   INSTR_WIDTH  combinational read data from instructionMemory
//   pc_out           out  ADDR_WIDTH   address to instructionMemory (= PC register)
//   if_instruction   out  INSTR_WIDTH  IF/ID instruction
//   if_pc            out  ADDR_WIDTH   address of if_instruction
//   if_valid         out  1            IF/ID holds a real instruction
//   halted           out  1            fetch stopped on HALT_INSTR
// BEHAVIOUR
//   - All state updates on posedge clock. Priority: reset > redirect > stall > normal/halt.
//   - Reset: PC=RESET_PC, if_instruction=NOP_INSTR, if_pc=0, if_valid=0, halted=0, state=RUN.
//   - pc_out is the PC register output directly (no combinational path from inputs).
//   - Latency: instruction at address A appears on if_instruction one cycle after pc_out=A.
//   - States: RUN, HALTED (halted = state==HALTED).
//   - RUN, no redirect, no stall, instruction_in != HALT_INSTR:
//     IF/ID <= {instruction_in, PC}, if_valid<=1, PC<=PC+1 (mod 2^ADDR_WIDTH; 0xFF -> 0x00).
//   - RUN, no redirect, no stall, instruction_in == HALT_INSTR:
//     IF/ID <= {HALT_INSTR, PC}, if_valid<=1, PC holds, state<=HALTED.
//   - HALTED, no redirect, no stall: PC holds, if_valid<=0, if_instruction<=NOP_INSTR.
//   - stall=1 (any state, no redirect): PC, IF/ID, if_valid, state all hold.
//   - redirect=1 (any state, stall ignored): PC<=redirect_target, if_valid<=0,
//     if_instruction<=NOP_INSTR, if_pc<=0, state<=RUN. Fetch at target begins next cycle.
//   - Redirect to current PC is legal: refetches it. Redirect while halted resumes execution.
//   - Reset asserted mid-stall/mid-redirect: reset values win that cycle, no residual state.
//   - No X on any output after first clock with reset=1.
// TESTING
//   1 Reset then run with mem[0..5]=08,28,40,60,88,B0: cycles 1..6 after reset release
//     -> if_instruction=08,28,40,60,88,B0, if_pc=0..5, if_valid=1; pc_out=1..6.
//   2 stall=1 for 3 cycles while pc_out=03 -> pc_out stays 03, if_instruction stays 40,
//     if_valid stays 1; after release next if_instruction=60.
//   3 redirect=1, redirect_target=05 at pc_out=02 -> next cycle pc_out=05, if_valid=0,
//     if_instruction=00; following cycle if_instruction=B0, if_pc=05.
//   4 mem[04]=FF -> if_instruction=FF, if_pc=04 for one cycle, halted=1, pc_out holds 04,
//     then if_valid=0; redirect to 00 -> halted=0, fetch resumes at 00.
//   5 PC wrap: redirect_target=FE, mem[FE]=11, mem[FF]=22, mem[00]=08
//     -> if_pc FE,FF,00 in order, pc_out 00 after FF.
//   6 redirect and stall together, then reset during a stall -> redirect wins;
//     reset yields pc_out=00, if_valid=0, halted=0 next cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// registers the returned instruction into IF/ID. Supports stall, redirect/flush and halt.
module fetch_stage #(
  parameter int                       ADDR_WIDTH  = 8,
  parameter int                       INSTR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]    RESET_PC    = 8'h00,
  parameter logic [INSTR_WIDTH-1:0]   HALT_INSTR  = 8'hFF,
  parameter logic [INSTR_WIDTH-1:0]   NOP_INSTR   = 8'h00
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic [ADDR_WIDTH-1:0]   redirect_target,
  input  logic [INSTR_WIDTH-1:0]  instruction_in,
  output logic [ADDR_WIDTH-1:0]   pc_out,
  output logic [INSTR_WIDTH-1:0]  if_instruction,
  output logic [ADDR_WIDTH-1:0]   if_pc,
  output logic                    if_valid,
  output logic                    halted
);

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]    ifpc_q, ifpc_d;
  logic                     valid_q, valid_d;

  // Priority: redirect > stall > normal fetch / halted idle (reset is applied in the register).
  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so no path
    // through this block leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;

    if (redirect) begin
      pc_d    = redirect_target;
      instr_d = NOP_INSTR;
      ifpc_d  = '0;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (!stall) begin
      unique case (state_q)
        RUN: begin
          instr_d = instruction_in;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          if (instruction_in == HALT_INSTR) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
        HALTED: begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values and simulation matches the synthesized flops.
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out         = pc_q;
  assign if_instruction = instr_q;
  assign if_pc          = ifpc_q;
  assign if_valid       = valid_q;
  assign halted         = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: combinational instruction-memory model, checks
// sampled on the falling edge against hand-computed expectations.
module tb_fetch_stage;

  logic       clock = 1'b0;
  logic       reset;
  logic       stall;
  logic       redirect;
  logic [7:0] redirect_target;
  logic [7:0] instruction_in;
  logic [7:0] pc_out;
  logic [7:0] if_instruction;
  logic [7:0] if_pc;
  logic       if_valid;
  logic       halted;

  logic [7:0] mem [256];
  int checks   = 0;
  int failures = 0;

  fetch_stage dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .instruction_in (instruction_in),
    .pc_out         (pc_out),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_valid       (if_valid),
    .halted         (halted)
  );

  always #5 clock = ~clock;

  assign instruction_in = mem[pc_out];

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge where outputs are sampled.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [7:0] exp_instr [6];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h08; mem[1] = 8'h28; mem[2] = 8'h40;
    mem[3] = 8'h60; mem[4] = 8'h88; mem[5] = 8'hB0;
    exp_instr[0] = 8'h08; exp_instr[1] = 8'h28; exp_instr[2] = 8'h40;
    exp_instr[3] = 8'h60; exp_instr[4] = 8'h88; exp_instr[5] = 8'hB0;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 8'h00;

    // Reset state
    step(); step();
    chk8("rst_pc", pc_out, 8'h00);
    chk8("rst_instr", if_instruction, 8'h00);
    chk8("rst_if_pc", if_pc, 8'h00);
    chk1("rst_valid", if_valid, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    reset = 1'b0;

    // 1: sequential fetch of mem[0..5]
    for (int i = 0; i < 6; i++) begin
      step();
      chk8($sformatf("run_instr%0d", i), if_instruction, exp_instr[i]);
      chk8($sformatf("run_if_pc%0d", i), if_pc, 8'(i));
      chk1($sformatf("run_valid%0d", i), if_valid, 1'b1);
      chk8($sformatf("run_pc%0d", i), pc_out, 8'(i + 1));
    end

    // 2: stall three cycles at pc_out=03
    do_reset();
    step(); step(); step();
    chk8("pre_stall_pc", pc_out, 8'h03);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk8($sformatf("stall_pc%0d", i), pc_out, 8'h03);
      chk8($sformatf("stall_instr%0d", i), if_instruction, 8'h40);
      chk1($sformatf("stall_valid%0d", i), if_valid, 1'b1);
    end
    stall = 1'b0;
    step();
    chk8("post_stall_instr", if_instruction, 8'h60);
    chk8("post_stall_if_pc", if_pc, 8'h03);
    chk8("post_stall_pc", pc_out, 8'h04);

    // 3: redirect to 05 at pc_out=02
    do_reset();
    step(); step();
    chk8("pre_redir_pc", pc_out, 8'h02);
    redirect = 1'b1; redirect_target = 8'h05;
    step();
    redirect = 1'b0;
    chk8("redir_pc", pc_out, 8'h05);
    chk1("redir_valid", if_valid, 1'b0);
    chk8("redir_instr", if_instruction, 8'h00);
    chk8("redir_if_pc", if_pc, 8'h00);
    step();
    chk8("redir_tgt_instr", if_instruction, 8'hB0);
    chk8("redir_tgt_if_pc", if_pc, 8'h05);
    chk1("redir_tgt_valid", if_valid, 1'b1);
    chk8("redir_tgt_pc", pc_out, 8'h06);

    // 4: halt on mem[04]=FF, then redirect to 00 resumes
    mem[4] = 8'hFF;
    do_reset();
    step(); step(); step(); step();
    chk8("pre_halt_pc", pc_out, 8'h04);
    chk1("pre_halt_halted", halted, 1'b0);
    step();
    chk8("halt_instr", if_instruction, 8'hFF);
    chk8("halt_if_pc", if_pc, 8'h04);
    chk1("halt_valid", if_valid, 1'b1);
    chk1("halt_halted", halted, 1'b1);
    chk8("halt_pc", pc_out, 8'h04);
    step();
    chk1("halted_valid", if_valid, 1'b0);
    chk8("halted_instr", if_instruction, 8'h00);
    chk1("halted_halted", halted, 1'b1);
    chk8("halted_pc", pc_out, 8'h04);
    redirect = 1'b1; redirect_target = 8'h00;
    step();
    redirect = 1'b0;
    chk1("resume_halted", halted, 1'b0);
    chk8("resume_pc", pc_out, 8'h00);
    chk1("resume_valid", if_valid, 1'b0);
    step();
    chk8("resume_instr", if_instruction, 8'h08);
    chk8("resume_if_pc", if_pc, 8'h00);
    chk8("resume_pc2", pc_out, 8'h01);
    mem[4] = 8'h88;

    // 5: PC wrap FE -> FF -> 00
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22;
    redirect = 1'b1; redirect_target = 8'hFE;
    step();
    redirect = 1'b0;
    chk8("wrap_pc_fe", pc_out, 8'hFE);
    step();
    chk8("wrap_instr_fe", if_instruction, 8'h11);
    chk8("wrap_if_pc_fe", if_pc, 8'hFE);
    chk8("wrap_pc_ff", pc_out, 8'hFF);
    step();
    chk8("wrap_instr_ff", if_instruction, 8'h22);
    chk8("wrap_if_pc_ff", if_pc, 8'hFF);
    chk8("wrap_pc_00", pc_out, 8'h00);
    step();
    chk8("wrap_instr_00", if_instruction, 8'h08);
    chk8("wrap_if_pc_00", if_pc, 8'h00);
    chk8("wrap_pc_01", pc_out, 8'h01);

    // 6: redirect beats stall; reset beats stall
    redirect = 1'b1; stall = 1'b1; redirect_target = 8'h03;
    step();
    redirect = 1'b0;
    chk8("rs_pc", pc_out, 8'h03);
    chk1("rs_valid", if_valid, 1'b0);
    step();
    chk8("rs_stall_pc", pc_out, 8'h03);
    chk1("rs_stall_valid", if_valid, 1'b0);
    reset = 1'b1;
    step();
    chk8("rst_stall_pc", pc_out, 8'h00);
    chk1("rst_stall_valid", if_valid, 1'b0);
    chk1("rst_stall_halted", halted, 1'b0);
    chk8("rst_stall_instr", if_instruction, 8'h00);
    reset = 1'b0; stall = 1'b0;
    step();
    chk8("after_rst_instr", if_instruction, 8'h08);
    chk8("after_rst_pc", pc_out, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
